fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller for the program-counter register. Every clock, the PC register loads the `pc_result` value this block produces.
- Sequences instruction fetch over a req/ack instruction-memory handshake, holds the PC on stall, and selects the next PC (sequential, branch, jump, jr, flush).
- Discards in-flight fetches made stale by a flush.
- Sits between the PC register, the instruction memory and the decode/control unit of the MIPS core.

Parameters:
RESET_VECTOR, 32'h00400024, PC value while reset is asserted and after reset.
FAULT_VECTOR, 32'h80000180, redirect target on a misaligned target (optional feature only).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  32  current PC from the PC register
pc_4  in  32  pc + 4 from the PC register
pc_result  out  32  next PC; the PC register loads it every rising edge
imem_req  out  1  fetch request, level; held until ack
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  instruction memory response valid (one cycle)
instr_valid  out  1  fetched instruction available to decode
stall  in  1  decode/execute cannot accept the instruction
branch_taken  in  1  taken branch for the issued instruction
branch_target  in  32  branch destination
jump  in  1  j/jal for the issued instruction
jump_index  in  26  instruction[25:0]
jr  in  1  jr/jalr for the issued instruction
jr_target  in  32  register-sourced target
flush  in  1  asynchronous-event redirect (exception/external)
flush_target  in  32  flush destination
issue_count  out  32  number of instructions accepted by decode

Behaviour:
- States: IDLE, FETCH, ISSUE, DRAIN. State and issue_count are registered; all other outputs are combinational from state and inputs.
- Reset (asynchronous, any state, mid-handshake included):
  - state = IDLE, issue_count = 0.
  - pc_result = RESET_VECTOR while reset is high.
  - imem_req = 0, instr_valid = 0.
- Default: pc_result = pc (hold) in every case not listed below.
- IDLE: imem_req = 0. Next state is FETCH unconditionally, one cycle after reset release.
- FETCH: imem_req = 1, imem_addr = pc.
  - Waits for imem_ack; on imem_ack → ISSUE.
- ISSUE: instr_valid = 1.
  - stall = 1: hold pc and stay in ISSUE. Redirect inputs are ignored.
  - stall = 0: go to FETCH, increment issue_count (wraps at 2^32), and drive pc_result by priority jr > jump > branch_taken > sequential:
    - jr: jr_target
    - jump: {pc_4[31:28], jump_index, 2'b00}
    - branch_taken: branch_target
    - otherwise: pc_4
  - Fetch-to-issue latency is the ack cycle + 1. Minimum issue interval is 2 cycles.
- flush (highest priority over stall and all redirects):
  - Sets pc_result = flush_target in every state except IDLE; no issue_count increment.
  - In FETCH without imem_ack: → DRAIN, since the outstanding response belongs to the old PC.
  - In FETCH with imem_ack in the same cycle: the response is discarded → FETCH.
  - In ISSUE: → FETCH; the issued instruction is dropped.
  - In DRAIN: stay in DRAIN with the new target.
- DRAIN: imem_req = 0, instr_valid = 0.
  - On imem_ack → FETCH; the data is discarded.
  - imem_ack and flush in the same cycle → FETCH with pc_result = flush_target.
- imem_ack outside FETCH/DRAIN is a protocol error and is ignored.
- Targets are passed unmodified; low bits are not masked.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output fetch_fault (1 bit), a one-cycle pulse.
  - If a selected next PC (redirect or flush target) has bits [1:0] ≠ 0, pc_result = FAULT_VECTOR and fetch_fault = 1 in that cycle.
  - The state transition is the same as for the original selection. issue_count still increments if it was an issue.
- Undefined: no fetch_fault port; the target is used as-is.

Test Plan:
- Reset release, ack 1 cycle after req → PC held at 0x00400024 through IDLE, imem_addr = 0x00400024, instr_valid on the cycle after ack; with stall = 0, pc → 0x00400028 and issue_count = 1.
- ISSUE with stall = 1 for 3 cycles, then jr = 1, jr_target = 0x00400100, branch_taken = 1 simultaneously → pc holds 3 cycles, then loads 0x00400100 (jr wins).
- pc = 0x00400030, jump = 1, jump_index = 26'h0100040 → pc_result = 0x00400100.
- flush in FETCH before ack, flush_target = 0x80000080, ack 2 cycles later → DRAIN, imem_req = 0, instr_valid never asserts for stale data, then FETCH at 0x80000080.
- Assert reset while in DRAIN and while instr_valid = 1 → immediate return to pc_result = 0x00400024, issue_count = 0, imem_req = 0.
- FETCH_ALIGN_CHECK_EN defined, branch_target = 0x00400102 → pc_result = 0x80000180, fetch_fault pulses once.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC-select and instruction-fetch sequencer: req/ack fetch, stall hold, jr/jump/branch/flush redirect.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h00400024
`ifdef FETCH_ALIGN_CHECK_EN
  , parameter logic [31:0] FAULT_VECTOR = 32'h80000180
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] pc_4,
  output logic [31:0] pc_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic [31:0] issue_count
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic      fetch_fault
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] issue_count_q, issue_count_d;
  logic [31:0] next_pc_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      issue_count_q <= issue_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_count_d = issue_count_q;
    next_pc_s     = pc;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (flush) begin
          // A response arriving with the flush is stale; without one, the old response is still owed.
          next_pc_s = flush_target;
          state_d   = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          state_d = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (flush) begin
          next_pc_s = flush_target;
          state_d   = FETCH;
        end else if (stall) begin
          instr_valid = 1'b1;
          state_d     = ISSUE;
        end else begin
          instr_valid   = 1'b1;
          state_d       = FETCH;
          issue_count_d = issue_count_q + 32'd1;
          if (jr) begin
            next_pc_s = jr_target;
          end else if (jump) begin
            next_pc_s = {pc_4[31:28], jump_index, 2'b00};
          end else if (branch_taken) begin
            next_pc_s = branch_target;
          end else begin
            next_pc_s = pc_4;
          end
        end
      end
      DRAIN: begin
        if (flush) begin
          next_pc_s = flush_target;
        end else begin
          next_pc_s = pc;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic redirect_s;
  logic misaligned_s;

  // Only explicit redirects and flush targets are alignment-checked; pc_4 and hold are not.
  always_comb begin
    redirect_s = 1'b0;
    case (state_q)
      FETCH:   redirect_s = flush;
      DRAIN:   redirect_s = flush;
      ISSUE:   redirect_s = flush | (~stall & (jr | jump | branch_taken));
      default: redirect_s = 1'b0;
    endcase
    misaligned_s = redirect_s & (next_pc_s[1:0] != 2'b00);
  end

  assign fetch_fault = ~reset & misaligned_s;
`endif

  always_comb begin
    if (reset) begin
      pc_result = RESET_VECTOR;
`ifdef FETCH_ALIGN_CHECK_EN
    end else if (misaligned_s) begin
      pc_result = FAULT_VECTOR;
`endif
    end else begin
      pc_result = next_pc_s;
    end
  end

  assign imem_addr   = pc;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC-register model and a fetch-address scoreboard.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h00400024;
  localparam logic [31:0] FV = 32'h80000180;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc_4;
  logic [31:0] pc_result;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        flush;
  logic [31:0] flush_target;
  logic [31:0] issue_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_fetch_q[$];

  fetch_sequencer dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_4(pc_4), .pc_result(pc_result),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target), .flush(flush), .flush_target(flush_target),
    .issue_count(issue_count)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clock = ~clock;

  // PC register: loads pc_result on every rising edge.
  always @(posedge clock) pc <= pc_result;
  assign pc_4 = pc + 32'd4;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_fetch(input string tag);
    logic [31:0] e;
    if (exp_fetch_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = exp_fetch_q.pop_front();
      chk(tag, imem_addr, e);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0; jr = 1'b0; jr_target = 32'd0; flush = 1'b0; flush_target = 32'd0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_pc_result", pc_result, RV);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", issue_count, 32'd0);

    // Release: IDLE holds, then FETCH at the reset vector, ack, issue sequential
    reset = 1'b0; #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_hold", pc_result, RV);
    exp_fetch_q.push_back(RV);
    tick(); #1;
    pop_fetch("fetch0_addr");
    chk("fetch0_valid", {31'd0, instr_valid}, 32'd0);
    tick(); imem_ack = 1'b1; #1;
    chk("fetch0_hold", pc_result, RV);
    tick(); imem_ack = 1'b0; #1;
    chk("issue0_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue0_seq", pc_result, 32'h00400028);
    exp_fetch_q.push_back(32'h00400028);
    tick(); #1;
    pop_fetch("fetch1_addr");
    chk("count1", issue_count, 32'd1);

    // Stall three cycles with redirects present, then jr beats branch
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; stall = 1'b1; jr = 1'b1; jr_target = 32'h00400100;
    branch_taken = 1'b1; branch_target = 32'h00400200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold", pc_result, 32'h00400028);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      tick();
    end
    stall = 1'b0; #1;
    chk("jr_wins", pc_result, 32'h00400100);
    exp_fetch_q.push_back(32'h00400100);
    tick(); jr = 1'b0; branch_taken = 1'b0; #1;
    pop_fetch("fetch_jr_addr");
    chk("count2", issue_count, 32'd2);

    // Branch to 0x00400030, then jump from there
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h00400030; #1;
    chk("branch_target", pc_result, 32'h00400030);
    exp_fetch_q.push_back(32'h00400030);
    tick(); branch_taken = 1'b0; #1;
    pop_fetch("fetch_br_addr");
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; jump = 1'b1; jump_index = 26'h0100040; #1;
    chk("jump_target", pc_result, 32'h00400100);
    exp_fetch_q.push_back(32'h00400100);
    tick(); jump = 1'b0; #1;
    pop_fetch("fetch_j_addr");
    chk("count4", issue_count, 32'd4);

    // Flush before ack: DRAIN discards the late ack, then refetch at the flush target
    flush = 1'b1; flush_target = 32'h80000080; #1;
    chk("flush_fetch_pc", pc_result, 32'h80000080);
    exp_fetch_q.push_back(32'h80000080);
    tick(); flush = 1'b0; #1;
    chk("drain_req", {31'd0, imem_req}, 32'd0);
    chk("drain_valid", {31'd0, instr_valid}, 32'd0);
    tick(); imem_ack = 1'b1; #1;
    chk("drain_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("drain_ack_hold", pc_result, 32'h80000080);
    tick(); imem_ack = 1'b0; #1;
    pop_fetch("fetch_after_drain");
    chk("no_stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("count_after_flush", issue_count, 32'd4);

    // Flush with ack in the same FETCH cycle: stays in FETCH
    flush = 1'b1; imem_ack = 1'b1; flush_target = 32'h80000100; #1;
    chk("flush_ack_pc", pc_result, 32'h80000100);
    exp_fetch_q.push_back(32'h80000100);
    tick(); flush = 1'b0; imem_ack = 1'b0; #1;
    pop_fetch("fetch_flush_ack");
    chk("flush_ack_valid", {31'd0, instr_valid}, 32'd0);

    // Flush in DRAIN retargets; flush + ack in DRAIN goes to FETCH at the new target
    flush = 1'b1; flush_target = 32'h80000200;
    tick(); flush_target = 32'h80000300; #1;
    chk("drain_reflush", pc_result, 32'h80000300);
    tick(); imem_ack = 1'b1; flush_target = 32'h80000400; #1;
    chk("drain_ack_flush", pc_result, 32'h80000400);
    exp_fetch_q.push_back(32'h80000400);
    tick(); flush = 1'b0; imem_ack = 1'b0; #1;
    pop_fetch("fetch_drain_flush");

    // Reset asserted while in DRAIN
    flush = 1'b1; flush_target = 32'h80000500;
    tick(); flush = 1'b0; reset = 1'b1; #1;
    chk("rst_drain_pc", pc_result, RV);
    chk("rst_drain_req", {31'd0, imem_req}, 32'd0);
    chk("rst_drain_count", issue_count, 32'd0);
    tick(); reset = 1'b0; #1;
    exp_fetch_q.push_back(RV);
    tick(); #1;
    pop_fetch("fetch_after_rst");
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; #1;
    chk("issue_after_rst", pc_result, 32'h00400028);
    exp_fetch_q.push_back(32'h00400028);
    tick(); #1;
    pop_fetch("fetch_after_rst2");
    chk("count_after_rst", issue_count, 32'd1);

    // Reset asserted while instr_valid is high
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; stall = 1'b1; #1;
    chk("valid_before_rst", {31'd0, instr_valid}, 32'd1);
    reset = 1'b1; #1;
    chk("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_issue_count", issue_count, 32'd0);
    chk("rst_issue_pc", pc_result, RV);
    chk("rst_issue_req", {31'd0, imem_req}, 32'd0);
    tick(); reset = 1'b0; stall = 1'b0; #1;
    exp_fetch_q.push_back(RV);
    tick(); #1;
    pop_fetch("fetch_after_rst3");

    // Misaligned branch target
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h00400102; #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_pc", pc_result, FV);
    chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
    exp_fetch_q.push_back(FV);
`else
    chk("misalign_passthru", pc_result, 32'h00400102);
    exp_fetch_q.push_back(32'h00400102);
`endif
    tick(); branch_taken = 1'b0; #1;
    pop_fetch("fetch_misalign");
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fault_pulse_end", {31'd0, fetch_fault}, 32'd0);
`endif
    chk("count_misalign", issue_count, 32'd1);

    chk("scoreboard_drained", exp_fetch_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
